// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the parametrised register file.
package regfile_pkg;

  typedef enum logic {RF_IDLE = 1'b0, RF_CLEAR = 1'b1} rf_state_t;

  localparam int RF_NUM_REGS = 8;
  localparam int RF_DATA_W   = 16;

endpackage

// File: rtl/rf_onehot_dec.sv
// ADDR_W-to-NUM_REGS one-hot decoder with enable; generates the per-register write strobe.
module rf_onehot_dec #(
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic                i_en,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [NUM_REGS-1:0] o_onehot
);

  // single hot bit at i_addr when enabled, all zero otherwise
  always_comb begin
    o_onehot = {NUM_REGS{1'b0}};
    if (i_en) begin
      o_onehot[i_addr] = 1'b1;
    end else begin
      o_onehot = {NUM_REGS{1'b0}};
    end
  end

endmodule

// File: rtl/param_regfile.sv
// Parametrised register file: two async read ports, handshaked write port, optional bypass,
// sequential bulk-clear engine. Optional hardwired-zero register 0 via PARAM_REGFILE_ZERO_REG_EN.
module param_regfile
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int DATA_W   = RF_DATA_W,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

`ifdef PARAM_REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  rf_state_t             r_state;
  logic [ADDR_W-1:0]     r_ptr;
  logic                  r_clr_done;
  logic [DATA_W-1:0]     w_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   w_wr_sel;
  logic                  w_wr_fire;
  logic                  w_wr_keep;

  assign clr_busy  = (r_state == RF_CLEAR);
  assign wr_ready  = !clr_busy;
  assign clr_done  = r_clr_done;
  assign w_wr_fire = wr_en && wr_ready;
  // writes to a hardwired-zero register 0 are accepted but dropped
  assign w_wr_keep = w_wr_fire && !(ZERO_REG && (wr_addr == {ADDR_W{1'b0}}));

  rf_onehot_dec #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_wr_dec (
    .i_en     (w_wr_keep),
    .i_addr   (wr_addr),
    .o_onehot (w_wr_sel)
  );

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if (ZERO_REG && (g == 0)) begin : g_zero
      assign w_regs[g] = {DATA_W{1'b0}};
    end else begin : g_flop
      logic [DATA_W-1:0] r_q;
      // storage: reset, sweep clear of this index, or accepted write
      always_ff @(posedge clk) begin
        if (rst) begin
          r_q <= {DATA_W{1'b0}};
        end else if (clr_busy && (r_ptr == ADDR_W'(g))) begin
          r_q <= {DATA_W{1'b0}};
        end else if (w_wr_sel[g]) begin
          r_q <= wr_data;
        end
      end
      assign w_regs[g] = r_q;
    end
  end

  // clear FSM; a request still high on the final edge chains straight into a new sweep
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RF_IDLE;
      r_ptr      <= {ADDR_W{1'b0}};
      r_clr_done <= 1'b0;
    end else begin
      case (r_state)
        RF_IDLE: begin
          r_clr_done <= 1'b0;
          if (clr_req) begin
            r_state <= RF_CLEAR;
            r_ptr   <= {ADDR_W{1'b0}};
          end
        end
        RF_CLEAR: begin
          r_ptr <= r_ptr + ADDR_W'(1);
          if (r_ptr == LAST_IDX) begin
            r_clr_done <= 1'b1;
            r_state    <= clr_req ? RF_CLEAR : RF_IDLE;
          end else begin
            r_clr_done <= 1'b0;
          end
        end
        default: begin
          r_state    <= RF_IDLE;
          r_ptr      <= {ADDR_W{1'b0}};
          r_clr_done <= 1'b0;
        end
      endcase
    end
  end

  // read muxes with optional same-cycle forwarding of the accepted write
  always_comb begin
    rd_data_a = w_regs[rd_addr_a];
    rd_data_b = w_regs[rd_addr_b];
    if ((BYPASS != 0) && w_wr_keep && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
    end else begin
      rd_data_a = w_regs[rd_addr_a];
    end
    if ((BYPASS != 0) && w_wr_keep && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
    end else begin
      rd_data_b = w_regs[rd_addr_b];
    end
  end

endmodule

// File: tb/tb_param_regfile.sv
// Bench for param_regfile: BYPASS=1 and BYPASS=0 instances share stimulus; a behavioural
// model is compared every cycle, plus hand-computed directed expectations.
module tb_param_regfile;

`ifdef PARAM_REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [15:0] wr_data = 16'h0000;
  logic [2:0]  rd_addr_a = 3'd0;
  logic [2:0]  rd_addr_b = 3'd0;
  logic        clr_req = 1'b0;

  logic        rdy1, busy1, done1, rdy0, busy0, done0;
  logic [15:0] rda1, rdb1, rda0, rdb0;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  logic [15:0] m_mem [8];
  bit          m_busy = 1'b0;
  int          m_cnt  = 0;
  bit          m_done = 1'b0;

  always #5 clk = ~clk;

  param_regfile #(.NUM_REGS(8), .DATA_W(16), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(rdy1), .rd_addr_a(rd_addr_a), .rd_data_a(rda1), .rd_addr_b(rd_addr_b),
    .rd_data_b(rdb1), .clr_req(clr_req), .clr_busy(busy1), .clr_done(done1)
  );

  param_regfile #(.NUM_REGS(8), .DATA_W(16), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(rdy0), .rd_addr_a(rd_addr_a), .rd_data_a(rda0), .rd_addr_b(rd_addr_b),
    .rd_data_b(rdb0), .clr_req(clr_req), .clr_busy(busy0), .clr_done(done0)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] mem_rd(input logic [2:0] a);
    if (ZR && a == 3'd0) return 16'h0000;
    return m_mem[a];
  endfunction

  // per-cycle model compare at negedge, model update at posedge
  initial begin
    bit keep;
    logic [15:0] ea, eb;
    forever begin
      @(negedge clk);
      keep = wr_en && !m_busy && !(ZR && wr_addr == 3'd0);
      if (chk_en) begin
        ea = (keep && wr_addr == rd_addr_a) ? wr_data : mem_rd(rd_addr_a);
        eb = (keep && wr_addr == rd_addr_b) ? wr_data : mem_rd(rd_addr_b);
        chk("model_rda_byp", rda1, ea);
        chk("model_rdb_byp", rdb1, eb);
        chk("model_rda_nobyp", rda0, mem_rd(rd_addr_a));
        chk("model_rdb_nobyp", rdb0, mem_rd(rd_addr_b));
        chk("model_ready", 16'({rdy1, rdy0}), m_busy ? 16'h0 : 16'h3);
        chk("model_busy", 16'({busy1, busy0}), m_busy ? 16'h3 : 16'h0);
        chk("model_done", 16'({done1, done0}), m_done ? 16'h3 : 16'h0);
      end
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < 8; i++) m_mem[i] = 16'h0000;
        m_busy = 1'b0; m_cnt = 0; m_done = 1'b0;
      end else begin
        m_done = 1'b0;
        if (keep) m_mem[wr_addr] = wr_data;
        if (m_busy) begin
          m_mem[m_cnt] = 16'h0000;
          m_cnt++;
          if (m_cnt == 8) begin
            m_done = 1'b1;
            m_cnt  = 0;
            m_busy = clr_req;
          end
        end else if (clr_req) begin
          m_busy = 1'b1;
          m_cnt  = 0;
        end
      end
    end
  end

  initial begin
    int busy_n, done_n, k;
    logic [15:0] d;

    step(); chk_en = 1'b1; step();
    rst = 1'b0;

    // reset state: every index reads zero, port idle
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
      @(negedge clk);
      chk("reset_rda", rda1, 16'h0000);
      chk("reset_rdb", rdb0, 16'h0000);
      chk("reset_ready", 16'(rdy1), 16'h0001);
      chk("reset_busy", 16'(busy1), 16'h0000);
      step();
    end

    // same-cycle bypass on both ports
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF; rd_addr_a = 3'd3; rd_addr_b = 3'd3;
    @(negedge clk);
    chk("bypass_a", rda1, 16'hBEEF);
    chk("bypass_b", rdb1, 16'hBEEF);
    chk("nobypass_same", rda0, 16'h0000);
    step(); wr_en = 1'b0;
    @(negedge clk);
    chk("nobypass_next", rda0, 16'hBEEF);

    // load r0..r7 then sweep
    for (int i = 0; i < 8; i++) begin
      d = 16'(16'h1111 * (i + 1));
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = d;
      step();
    end
    wr_en = 1'b0; rd_addr_a = 3'd2; rd_addr_b = 3'd5;
    clr_req = 1'b1; step(); clr_req = 1'b0;
    busy_n = 0; done_n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy1) begin
        k = busy_n;
        busy_n++;
        chk("sweep_ready_low", 16'(rdy1), 16'h0000);
        if (k == 2) chk("sweep_k2_r2_old", rda1, 16'h3333);
        if (k == 3) begin
          chk("sweep_k3_r2_zero", rda1, 16'h0000);
          chk("sweep_k3_r5_old", rdb1, 16'h6666);
        end
      end
      if (done1) done_n++;
      step();
    end
    chk("sweep_busy_cycles", 16'(busy_n), 16'd8);
    chk("sweep_done_pulses", 16'(done_n), 16'd1);
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i);
      @(negedge clk);
      chk("after_sweep_zero", rda0, 16'h0000);
      step();
    end

    // write held through a sweep lands only after busy falls
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h5A5A; step();
    wr_data = 16'hABCD; wr_addr = 3'd4; clr_req = 1'b1; step();
    clr_req = 1'b0; wr_addr = 3'd6; wr_data = 16'h1234; rd_addr_a = 3'd6; rd_addr_b = 3'd4;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!busy1) break;
      k++;
      step();
    end
    chk("held_write_wait", 16'(k), 16'd8);
    chk("held_write_bypass", rda1, 16'h1234);
    chk("held_write_before", rda0, 16'h0000);
    chk("clr_with_write_r4", rdb0, 16'h0000);
    step(); wr_en = 1'b0;
    @(negedge clk);
    chk("held_write_landed", rda0, 16'h1234);

    // reset in the middle of a sweep
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 16'h0F0F; step();
    end
    wr_en = 1'b0;
    clr_req = 1'b1; step(); clr_req = 1'b0;
    step(); step(); step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 16'(busy1), 16'h0000);
    chk("rst_mid_ready", 16'(rdy0), 16'h0001);
    done_n = 0;
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i); rd_addr_b = 3'(i);
      @(negedge clk);
      if (done1 || done0) done_n++;
      chk("rst_mid_zero", rda0, 16'h0000);
      step();
    end
    chk("rst_mid_no_done", 16'(done_n), 16'd0);

`ifdef PARAM_REGFILE_ZERO_REG_EN
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF; rd_addr_a = 3'd0; rd_addr_b = 3'd0;
    @(negedge clk);
    chk("zero_reg_ready", 16'(rdy1), 16'h0001);
    chk("zero_reg_a_same", rda1, 16'h0000);
    chk("zero_reg_b_same", rdb1, 16'h0000);
    step(); wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("zero_reg_a_later", rda1, 16'h0000);
      chk("zero_reg_b_later", rdb0, 16'h0000);
      step();
    end
`endif

    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
